// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-pmem arbiter: line type and arbiter FSM states.
package cache_arbiter_pkg;

  localparam int unsigned LINE_BITS = 128;
  localparam int unsigned ADDR_BITS = 16;

  typedef logic [LINE_BITS-1:0] lc3b_line;
  typedef logic [ADDR_BITS-1:0] lc3b_word;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ICACHE = 2'd1,
    S_DCACHE = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/cache_arbiter_control.sv
// Grant FSM for the cache arbiter; fixed D-cache priority unless
// ARB_ROUND_ROBIN_EN is defined, which adds a last_grant register.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic pmem_resp_i,
  output logic sel_i_o,
  output logic sel_d_o
);

  lc3b_arb_state state_q;
  logic          sel_i_q;
  logic          sel_d_q;
  logic          grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Set after an I grant; the reset value lets the I-cache win the first tie.
  logic last_grant_q;
  always_comb grant_d = d_req_i & (~i_req_i | last_grant_q);
`else
  always_comb grant_d = d_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sel_i_q <= 1'b0;
      sel_d_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            state_q <= S_DCACHE;
            sel_d_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
          end else if (i_req_i) begin
            state_q <= S_ICACHE;
            sel_i_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
          end
        end
        S_ICACHE, S_DCACHE: begin
          if (pmem_resp_i) begin
            state_q <= S_IDLE;
            sel_i_q <= 1'b0;
            sel_d_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          sel_i_q <= 1'b0;
          sel_d_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_i_o = sel_i_q;
  assign sel_d_o = sel_d_q;

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-cache reads and D-cache reads/writes onto one pmem port.
// Optional ARB_ROUND_ROBIN_EN macro switches tie-breaking to round robin.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              I_pmem_read,
  input  logic [ADDR_W-1:0] I_pmem_address,
  output logic              I_pmem_resp,
  output logic [LINE_W-1:0] I_pmem_rdata,
  input  logic              D_pmem_read,
  input  logic              D_pmem_write,
  input  logic [ADDR_W-1:0] D_pmem_address,
  input  logic [LINE_W-1:0] D_pmem_wdata,
  output logic              D_pmem_resp,
  output logic [LINE_W-1:0] D_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  logic sel_i;
  logic sel_d;

  cache_arbiter_control u_control (
    .clk_i       (clk),
    .reset_i     (reset),
    .i_req_i     (I_pmem_read),
    .d_req_i     (D_pmem_read | D_pmem_write),
    .pmem_resp_i (pmem_resp),
    .sel_i_o     (sel_i),
    .sel_d_o     (sel_d)
  );

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    I_pmem_resp  = 1'b0;
    D_pmem_resp  = 1'b0;
    if (sel_i) begin
      pmem_read    = I_pmem_read;
      pmem_address = I_pmem_address;
      I_pmem_resp  = pmem_resp;
    end else if (sel_d) begin
      // Simultaneous read and write is a write-back.
      pmem_read    = D_pmem_read & ~D_pmem_write;
      pmem_write   = D_pmem_write;
      pmem_address = D_pmem_address;
      pmem_wdata   = D_pmem_wdata;
      D_pmem_resp  = pmem_resp;
    end
  end

  assign I_pmem_rdata = pmem_rdata;
  assign D_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

  logic         clk;
  logic         reset;
  logic         I_pmem_read;
  logic [15:0]  I_pmem_address;
  logic         I_pmem_resp;
  logic [127:0] I_pmem_rdata;
  logic         D_pmem_read;
  logic         D_pmem_write;
  logic [15:0]  D_pmem_address;
  logic [127:0] D_pmem_wdata;
  logic         D_pmem_resp;
  logic [127:0] D_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  cache_arbiter #(.LINE_W(128), .ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .I_pmem_read    (I_pmem_read),
    .I_pmem_address (I_pmem_address),
    .I_pmem_resp    (I_pmem_resp),
    .I_pmem_rdata   (I_pmem_rdata),
    .D_pmem_read    (D_pmem_read),
    .D_pmem_write   (D_pmem_write),
    .D_pmem_address (D_pmem_address),
    .D_pmem_wdata   (D_pmem_wdata),
    .D_pmem_resp    (D_pmem_resp),
    .D_pmem_rdata   (D_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    I_pmem_read = 1'b0; I_pmem_address = '0;
    D_pmem_read = 1'b0; D_pmem_write = 1'b0; D_pmem_address = '0; D_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({pmem_read, pmem_write, I_pmem_resp, D_pmem_resp} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, I_pmem_resp, D_pmem_resp});
    else pass_cnt++;
    total_cnt++;
    if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) $display("FAIL reset_data: got addr %h wdata %h expected 0", pmem_address, pmem_wdata);
    else pass_cnt++;
  endtask

  task automatic test_i_read();
    tick();
    I_pmem_read = 1'b1; I_pmem_address = 16'h1230;
    #1;
    total_cnt++;
    if (pmem_read !== 1'b0) $display("FAIL i_read_c0: got pmem_read %b expected 0", pmem_read);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) $display("FAIL i_read_c1: got r%b w%b addr %h expected r1 w0 addr 1230", pmem_read, pmem_write, pmem_address);
    else pass_cnt++;
    tick(); tick(); #1;
    total_cnt++;
    if (I_pmem_resp !== 1'b0 || D_pmem_resp !== 1'b0) $display("FAIL i_read_c3: got I_resp %b D_resp %b expected 0 0", I_pmem_resp, D_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1; pmem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    total_cnt++;
    if (I_pmem_resp !== 1'b1 || D_pmem_resp !== 1'b0) $display("FAIL i_read_resp: got I_resp %b D_resp %b expected 1 0", I_pmem_resp, D_pmem_resp);
    else pass_cnt++;
    total_cnt++;
    if (I_pmem_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 || D_pmem_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) $display("FAIL i_read_rdata: got I %h D %h expected 0123456789abcdeffedcba9876543210", I_pmem_rdata, D_pmem_rdata);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0; I_pmem_read = 1'b0; I_pmem_address = '0;
    #1;
    total_cnt++;
    if (pmem_read !== 1'b0 || I_pmem_resp !== 1'b0) $display("FAIL i_read_done: got pmem_read %b I_resp %b expected 0 0", pmem_read, I_pmem_resp);
    else pass_cnt++;
  endtask

  task automatic test_d_write();
    D_pmem_write = 1'b1; D_pmem_address = 16'h8000; D_pmem_wdata = {16{8'hA5}};
    tick(); #1;
    total_cnt++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000) $display("FAIL d_write_ctrl: got r%b w%b addr %h expected r0 w1 addr 8000", pmem_read, pmem_write, pmem_address);
    else pass_cnt++;
    total_cnt++;
    if (pmem_wdata !== {16{8'hA5}}) $display("FAIL d_write_wdata: got %h expected a5 repeated", pmem_wdata);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== 1'b1 || I_pmem_resp !== 1'b0) $display("FAIL d_write_resp: got D_resp %b I_resp %b expected 1 0", D_pmem_resp, I_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    #1;
    // Still requesting, but the FSM is back in IDLE for this cycle.
    total_cnt++;
    if (pmem_write !== 1'b0 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0) $display("FAIL d_write_idle: got w%b addr %h wdata %h expected 0", pmem_write, pmem_address, pmem_wdata);
    else pass_cnt++;
    D_pmem_write = 1'b0; D_pmem_address = '0; D_pmem_wdata = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [15:0] first_addr, second_addr;
    logic        first_is_d;
`ifdef ARB_ROUND_ROBIN_EN
    first_is_d = 1'b0; first_addr = 16'h0040; second_addr = 16'h2000;
`else
    first_is_d = 1'b1; first_addr = 16'h2000; second_addr = 16'h0040;
`endif
    I_pmem_read = 1'b1; I_pmem_address = 16'h0040;
    D_pmem_read = 1'b1; D_pmem_address = 16'h2000;
    tick(); #1;
    total_cnt++;
    if (pmem_read !== 1'b1 || pmem_address !== first_addr) $display("FAIL sim_first: got r%b addr %h expected r1 addr %h", pmem_read, pmem_address, first_addr);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== first_is_d || I_pmem_resp !== ~first_is_d) $display("FAIL sim_first_resp: got D %b I %b expected D %b I %b", D_pmem_resp, I_pmem_resp, first_is_d, ~first_is_d);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    if (first_is_d) D_pmem_read = 1'b0; else I_pmem_read = 1'b0;
    #1;
    total_cnt++;
    if (pmem_read !== 1'b0 || pmem_address !== 16'h0) $display("FAIL sim_gap: got r%b addr %h expected r0 addr 0000", pmem_read, pmem_address);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (pmem_read !== 1'b1 || pmem_address !== second_addr) $display("FAIL sim_second: got r%b addr %h expected r1 addr %h", pmem_read, pmem_address, second_addr);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== ~first_is_d || I_pmem_resp !== first_is_d) $display("FAIL sim_second_resp: got D %b I %b expected D %b I %b", D_pmem_resp, I_pmem_resp, ~first_is_d, first_is_d);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0; I_pmem_read = 1'b0; D_pmem_read = 1'b0;
    I_pmem_address = '0; D_pmem_address = '0;
    tick();
  endtask

  task automatic test_no_preempt();
    I_pmem_read = 1'b1; I_pmem_address = 16'h0500;
    tick();
    // I-cache abandons its request and the D-cache asks while I still holds the grant.
    I_pmem_read = 1'b0; D_pmem_write = 1'b1; D_pmem_address = 16'h0600;
    #1;
    total_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== 16'h0500) $display("FAIL drop_follow: got r%b w%b addr %h expected r0 w0 addr 0500", pmem_read, pmem_write, pmem_address);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (I_pmem_resp !== 1'b1 || D_pmem_resp !== 1'b0) $display("FAIL no_preempt_resp: got I %b D %b expected I 1 D 0", I_pmem_resp, D_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    tick(); #1;
    total_cnt++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h0600) $display("FAIL waiter_granted: got w%b addr %h expected w1 addr 0600", pmem_write, pmem_address);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; D_pmem_write = 1'b0; D_pmem_address = '0; I_pmem_address = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    D_pmem_read = 1'b1; D_pmem_address = 16'h3000;
    tick(); #1;
    total_cnt++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3000) $display("FAIL rmid_grant: got r%b addr %h expected r1 addr 3000", pmem_read, pmem_address);
    else pass_cnt++;
    reset = 1'b1; D_pmem_read = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== 16'h0) $display("FAIL rmid_idle: got r%b w%b addr %h expected 0", pmem_read, pmem_write, pmem_address);
    else pass_cnt++;
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== 1'b0 || I_pmem_resp !== 1'b0) $display("FAIL rmid_late_resp: got D %b I %b expected 0 0", D_pmem_resp, I_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    D_pmem_address = '0;
  endtask

  task automatic test_idle_resp();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== 1'b0 || I_pmem_resp !== 1'b0) $display("FAIL idle_resp: got D %b I %b expected 0 0", D_pmem_resp, I_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0;
    I_pmem_read = 1'b1; I_pmem_address = 16'h0700;
    #1;
    // Still IDLE: a fresh request is not yet driven onto pmem.
    total_cnt++;
    if (pmem_read !== 1'b0) $display("FAIL idle_stays: got r%b expected r0", pmem_read);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0700) $display("FAIL idle_then_grant: got r%b addr %h expected r1 addr 0700", pmem_read, pmem_address);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; I_pmem_read = 1'b0; I_pmem_address = '0;
    tick();
  endtask

  task automatic test_rw_both();
    D_pmem_read = 1'b1; D_pmem_write = 1'b1; D_pmem_address = 16'h0100; D_pmem_wdata = 128'h5A;
    tick(); #1;
    total_cnt++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h0100 || pmem_wdata !== 128'h5A) $display("FAIL rw_both: got r%b w%b addr %h wdata %h expected r0 w1 addr 0100 wdata 5a", pmem_read, pmem_write, pmem_address, pmem_wdata);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (D_pmem_resp !== 1'b1) $display("FAIL rw_both_resp: got D %b expected 1", D_pmem_resp);
    else pass_cnt++;
    tick();
    pmem_resp = 1'b0; D_pmem_read = 1'b0; D_pmem_write = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_no_preempt();
    test_reset_mid();
    test_idle_resp();
    test_rw_both();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
